serial_word_rx: RTL and testbench
=================================

# serial_word_rx

Serial-to-parallel receiver for the far end of the team's shift-register serial links. It accepts one bit per qualified clock on a serial input and assembles `WIDTH`-bit words in either shift direction: right-shift (LSB-first) or left-shift (MSB-first). Each completed word is presented on a registered parallel output with a valid/ready handshake. Words that arrive while the output is still occupied are flagged as overruns.

## Interface
- `WIDTH`, default 4: word width in bits, must be at least 2.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `sin` in 1: serial data bit.
- `sin_valid` in 1: `sin` is accepted on this edge.
- `dir` in 1: shift direction.
  - 0 = right-shift, LSB-first: the new bit enters the MSB, as `{sin, sh[WIDTH-1:1]}`.
  - 1 = left-shift, MSB-first: the new bit enters the LSB, as `{sh[WIDTH-2:0], sin}`.
- `clr` in 1: synchronous abort of the partial word; also clears `overrun`.
- `out_ready` in 1: consumer accepts `out_data` on this edge.
- `out_data` out `WIDTH`: last completed word.
- `out_valid` out 1: `out_data` holds an unconsumed word.
- `bit_cnt` out `$clog2(WIDTH)`: bits collected in the current partial word.
- `overrun` out 1: sticky; a completed word was dropped.

## Operation
- Internal state:
  - Shift register `sh[WIDTH-1:0]`.
  - Bit counter `bit_cnt`, range 0..WIDTH-1.
  - Latched direction `dir_q`.
  - Output register `out_data` with flag `out_valid`.
- Receive FSM has two states:
  - IDLE: `bit_cnt` = 0.
  - RECV: 0 < `bit_cnt` < WIDTH.
- Transitions:
  - IDLE --`sin_valid`--> RECV. `dir` is latched into `dir_q` on this edge, and the first bit is shifted using `dir`.
  - RECV --`sin_valid`, `bit_cnt` < WIDTH-1--> RECV, shifting with `dir_q`. Changes on `dir` mid-word are ignored.
  - RECV --`sin_valid`, `bit_cnt` == WIDTH-1--> IDLE. The word completes, `bit_cnt` goes to 0 and `sh` goes to 0.
  - Any state --`clr`--> IDLE. `sh` = 0, `bit_cnt` = 0, `overrun` = 0. `clr` has priority over `sin_valid`, so a bit offered in the same cycle is discarded. `clr` does not touch `out_data` or `out_valid`.
- `sin_valid` low: `sh`, `bit_cnt` and `dir_q` hold. Gaps of any length between bits are legal.
- Word completion: the completed value is the shifted `sh`, including the final bit.
  - If `out_valid` is 0, or `out_valid` and `out_ready` are both 1 on the same edge: load `out_data` and set `out_valid` = 1.
  - Otherwise: drop the word, keep `out_data`/`out_valid` unchanged, set `overrun` = 1.
- Drain: `out_valid` && `out_ready` with no completion on that edge clears `out_valid` to 0. `out_data` keeps its last value.
- `out_ready` while `out_valid` = 0 has no effect.
- `overrun` stays set until `clr` or reset.

## Timing
- Reset (`rst` = 0) takes effect immediately, without a clock edge, and holds while low. Values in reset:
  - `out_data` = 0
  - `out_valid` = 0
  - `bit_cnt` = 0
  - `overrun` = 0
  - `sh` = 0
  - `dir_q` = 0
- Reset asserted mid-word discards the partial word. The first `sin_valid` after release starts a new word.
- Latency: the word completing on edge k has `out_valid` = 1 and `out_data` valid immediately after edge k.
- `out_valid` holds until the handshake edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Throughput: one word per WIDTH accepted bits. Back-to-back words need no idle cycle.

## Test plan
- LSB-first (WIDTH=4):
  - Stimulus: `dir`=0; bits 1,0,1,1 (first to last) on 4 consecutive edges; `out_ready`=0.
  - Response: `out_data`=4'b1101, `out_valid`=1 after the 4th edge; `bit_cnt` sequence 1,2,3,0.
- MSB-first with gaps:
  - Stimulus: `dir`=1; bits 1,0,1,1 with 2 idle cycles between each; `dir` toggled mid-word.
  - Response: `out_data`=4'b1011; the mid-word `dir` toggle has no effect.
- Backpressure:
  - Stimulus: `out_ready`=0; word 4'hA then word 4'h5 streamed; then `out_ready`=1 for one cycle.
  - Response: after the 8th bit, `out_data`=4'hA and `overrun`=1. After the handshake, `out_valid`=0 and `overrun` stays 1.
- Simultaneous drain and completion:
  - Stimulus: `out_valid`=1 holding 4'h3; `out_ready`=1 on the same edge as the last bit of 4'hC.
  - Response: `out_data`=4'hC, `out_valid` stays 1, `overrun`=0.
- `clr` abort:
  - Stimulus: 2 bits, then `clr`=1 together with `sin_valid`=1, then bits 0,1,1,0 with `dir`=0.
  - Response: `bit_cnt`=0 after the `clr` edge; `out_data`=4'b0110; `overrun` cleared.
- Async reset:
  - Stimulus: `rst` pulled low between clock edges after 3 bits, with `out_valid`=1.
  - Response: all outputs 0 before the next edge. After release, 4 fresh bits produce exactly one word.

Source files
------------

// File: rtl/serial_word_rx_if.sv
// Port bundle for serial_word_rx: serial bit input, abort, and the parallel
// word output with its valid/ready handshake and status.
interface serial_word_rx_if #(
    parameter int WIDTH = 4
);
    localparam int CW = $clog2(WIDTH);

    logic             sin;
    logic             sin_valid;
    logic             dir;
    logic             clr;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [CW-1:0]    bit_cnt;
    logic             overrun;

    modport master (
        output sin, sin_valid, dir, clr, out_ready,
        input  out_data, out_valid, bit_cnt, overrun
    );

    modport slave (
        input  sin, sin_valid, dir, clr, out_ready,
        output out_data, out_valid, bit_cnt, overrun
    );
endinterface

// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver: collects WIDTH bits LSB- or MSB-first and
// presents each word on a registered valid/ready output, flagging overruns.
module serial_word_rx #(
    parameter int WIDTH = 4
) (
    input logic             clk,
    input logic             rst,
    serial_word_rx_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d, shifted, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d, shift_dir;
    logic             valid_d, ovr_d, complete;

    assign bus.bit_cnt = cnt_q;

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        data_d   = bus.out_data;
        valid_d  = bus.out_valid;
        ovr_d    = bus.overrun;
        complete = 1'b0;

        // The first bit of a word uses the live dir; later bits use the latched one.
        shift_dir = (state_q == IDLE) ? bus.dir : dir_q;
        shifted   = shift_dir ? {sh_q[WIDTH-2:0], bus.sin} : {bus.sin, sh_q[WIDTH-1:1]};

        if (bus.clr) begin
            state_d = IDLE;
            sh_d    = '0;
            cnt_d   = '0;
            ovr_d   = 1'b0;
        end else if (bus.sin_valid) begin
            if (state_q == IDLE) dir_d = bus.dir;
            if (cnt_q == LAST) begin
                complete = 1'b1;
                state_d  = IDLE;
                sh_d     = '0;
                cnt_d    = '0;
            end else begin
                state_d = RECV;
                sh_d    = shifted;
                cnt_d   = cnt_q + 1'b1;
            end
        end

        // A drain on the completion edge frees the slot for the new word.
        if (complete) begin
            if (!bus.out_valid || bus.out_ready) begin
                data_d  = shifted;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (bus.out_valid && bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            sh_q          <= '0;
            cnt_q         <= '0;
            dir_q         <= 1'b0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sh_q          <= sh_d;
            cnt_q         <= cnt_d;
            dir_q         <= dir_d;
            bus.out_data  <= data_d;
            bus.out_valid <= valid_d;
            bus.overrun   <= ovr_d;
        end
    end
endmodule

// File: tb/tb_serial_word_rx.sv
// Self-checking bench for serial_word_rx (WIDTH=4) with a word scoreboard.
module tb_serial_word_rx;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    serial_word_rx_if #(.WIDTH(WIDTH)) bus ();

    serial_word_rx #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [WIDTH-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_pop_check(input string tag);
        logic [WIDTH-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_underflow"}, exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            check(tag, bus.out_data, e);
            check({tag, "_valid"}, bus.out_valid, 1);
        end
    endtask

    // Sends w serially; bit order follows d. Checks bit_cnt after every bit.
    task automatic send_word(input logic [WIDTH-1:0] w, input logic d,
                             input bit accept, input bit ready_last, input string tag);
        if (accept) exp_q.push_back(w);
        for (int i = 0; i < WIDTH; i++) begin
            bus.sin       = d ? w[WIDTH-1-i] : w[i];
            bus.sin_valid = 1'b1;
            bus.dir       = d;
            if (i == WIDTH - 1 && ready_last) bus.out_ready = 1'b1;
            tick();
            bus.sin_valid = 1'b0;
            bus.out_ready = 1'b0;
            check($sformatf("%s_cnt%0d", tag, i), bus.bit_cnt, (i + 1) % WIDTH);
        end
        if (accept) sb_pop_check(tag);
    endtask

    task automatic drain(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_drained"}, bus.out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] bits;
        bus.sin = 1'b0; bus.sin_valid = 1'b0; bus.dir = 1'b0;
        bus.clr = 1'b0; bus.out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_data", bus.out_data, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_cnt", bus.bit_cnt, 0);
        check("rst_ovr", bus.overrun, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // LSB-first: bits 1,0,1,1 -> 4'b1101
        send_word(4'b1101, 1'b0, 1'b1, 1'b0, "lsb");
        drain("lsb");

        // MSB-first, 2 idle cycles between bits, dir flipped after the first bit
        bits = 4'b1101;   // bit order: 1,0,1,1
        exp_q.push_back(4'b1011);
        for (int i = 0; i < WIDTH; i++) begin
            bus.sin = bits[i]; bus.sin_valid = 1'b1;
            bus.dir = (i == 0) ? 1'b1 : 1'b0;
            tick();
            bus.sin_valid = 1'b0;
            bus.dir = ~bus.dir;
            tick();
            bus.dir = ~bus.dir;
            tick();
        end
        sb_pop_check("msb_gap");
        drain("msb_gap");

        // Backpressure: second word is dropped
        send_word(4'hA, 1'b0, 1'b1, 1'b0, "bp_a");
        send_word(4'h5, 1'b0, 1'b0, 1'b0, "bp_5");
        check("bp_data_kept", bus.out_data, 4'hA);
        check("bp_valid", bus.out_valid, 1);
        check("bp_ovr", bus.overrun, 1);
        drain("bp");
        check("bp_ovr_sticky", bus.overrun, 1);

        // clr abort, with a bit offered on the same edge
        bus.dir = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.sin = 1'b1; bus.sin_valid = 1'b1; tick();
        end
        bus.clr = 1'b1; bus.sin = 1'b1;
        tick();
        bus.clr = 1'b0; bus.sin_valid = 1'b0;
        check("clr_cnt", bus.bit_cnt, 0);
        check("clr_ovr", bus.overrun, 0);
        send_word(4'b0110, 1'b0, 1'b1, 1'b0, "clr_word");
        drain("clr");

        // Drain and completion on the same edge
        send_word(4'h3, 1'b1, 1'b1, 1'b0, "sim_3");
        send_word(4'hC, 1'b0, 1'b1, 1'b1, "sim_c");
        check("sim_ovr", bus.overrun, 0);

        // Async reset mid-word with out_valid and overrun set
        send_word(4'h7, 1'b0, 1'b0, 1'b0, "pre_rst");
        check("pre_rst_ovr", bus.overrun, 1);
        for (int i = 0; i < 3; i++) begin
            bus.sin = 1'b1; bus.sin_valid = 1'b1; tick();
        end
        bus.sin_valid = 1'b0;
        check("pre_rst_cnt", bus.bit_cnt, 3);
        #2 rst = 1'b0;
        #1;
        check("arst_data", bus.out_data, 0);
        check("arst_valid", bus.out_valid, 0);
        check("arst_cnt", bus.bit_cnt, 0);
        check("arst_ovr", bus.overrun, 0);
        #2 rst = 1'b1;
        tick();
        check("post_rst_valid", bus.out_valid, 0);
        send_word(4'h9, 1'b1, 1'b1, 1'b0, "post_rst");
        check("post_rst_ovr", bus.overrun, 0);
        tick();
        check("post_rst_hold", bus.out_valid, 1);

        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
